// File: rtl/nes_multi_reader.sv
// Polls up to four NES controllers in parallel over a shared latch/clock pair
// and publishes debounced-by-frame button state with rising-edge flags.
module nes_multi_reader #(
    parameter int NUM_PADS    = 2,
    parameter int HALF_PERIOD = 151,
    parameter int POLL_PERIOD = 419583
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_PADS-1:0]   nes_data,
    output logic                  nes_latch,
    output logic                  nes_clk,
    output logic [8*NUM_PADS-1:0] buttons,
    output logic [8*NUM_PADS-1:0] pressed,
    output logic                  valid,
    output logic                  overrun
);

    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int HW = $clog2(2 * HALF_PERIOD);

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [HW-1:0] LATCH_LAST = HW'(2 * HALF_PERIOD - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LOW,
        CLK_HIGH,
        DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [PW-1:0]               poll_cnt;
    logic [HW-1:0]               hp_cnt;
    logic [HW-1:0]               hp_next;
    logic [2:0]                  bit_idx;
    logic [2:0]                  bit_next;
    logic [NUM_PADS-1:0][6:0]    shift;
    logic                        tick;
    logic                        sample;
    logic                        publish;
    logic [8*NUM_PADS-1:0]       frame_bits;

    assign tick = (poll_cnt == POLL_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            poll_cnt  <= '0;
            hp_cnt    <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            nes_latch <= 1'b0;
            nes_clk   <= 1'b0;
            buttons   <= '0;
            pressed   <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            poll_cnt  <= tick ? '0 : poll_cnt + 1'b1;
            state     <= state_next;
            hp_cnt    <= hp_next;
            bit_idx   <= bit_next;
            // Pins are registered from the next state so they line up with the state itself.
            nes_latch <= (state_next == LATCH);
            nes_clk   <= (state_next == CLK_HIGH);
            valid     <= publish;
            if (sample && bit_idx != 3'd7) begin
                for (int p = 0; p < NUM_PADS; p++) begin
                    shift[p][bit_idx] <= nes_data[p];
                end
            end
            if (publish) begin
                buttons <= frame_bits;
                pressed <= frame_bits & ~buttons;
            end else begin
                pressed <= '0;
            end
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        hp_next    = hp_cnt;
        bit_next   = bit_idx;
        case (state)
            IDLE: begin
                hp_next  = '0;
                bit_next = '0;
                if (tick && enable) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                if (hp_cnt == LATCH_LAST) begin
                    hp_next    = '0;
                    state_next = CLK_LOW;
                end else begin
                    hp_next = hp_cnt + 1'b1;
                end
            end
            CLK_LOW: begin
                if (hp_cnt == HALF_LAST) begin
                    hp_next    = '0;
                    state_next = (bit_idx == 3'd7) ? DONE : CLK_HIGH;
                end else begin
                    hp_next = hp_cnt + 1'b1;
                end
            end
            CLK_HIGH: begin
                if (hp_cnt == HALF_LAST) begin
                    hp_next    = '0;
                    bit_next   = bit_idx + 3'd1;
                    state_next = CLK_LOW;
                end else begin
                    hp_next = hp_cnt + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The final sample goes straight into the published word, so valid lands in the DONE cycle.
    always_comb begin
        sample     = (state == CLK_LOW) && (hp_cnt == HALF_LAST);
        publish    = sample && (bit_idx == 3'd7);
        frame_bits = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            frame_bits[8*p +: 8] = ~{nes_data[p], shift[p]};
        end
    end

endmodule

// File: tb/tb_nes_multi_reader.sv
// Self-checking bench for nes_multi_reader: emulated pads plus a timing model
// derived from frame offsets relative to each accepted poll tick.
module tb_nes_multi_reader;

    localparam int NP    = 2;
    localparam int H     = 2;
    localparam int P     = 64;
    localparam int P2    = 20;
    localparam int FRAME = 17 * H + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic [NP-1:0]   nes_data = '1;
    logic            nes_latch, nes_clk, valid, overrun;
    logic [8*NP-1:0] buttons, pressed;
    logic            nes_latch_b, nes_clk_b, valid_b, overrun_b;
    logic [8*NP-1:0] buttons_b, pressed_b;

    nes_multi_reader #(.NUM_PADS(NP), .HALF_PERIOD(H), .POLL_PERIOD(P)) dut (
        .clk(clk), .reset(reset), .enable(enable), .nes_data(nes_data),
        .nes_latch(nes_latch), .nes_clk(nes_clk), .buttons(buttons),
        .pressed(pressed), .valid(valid), .overrun(overrun)
    );

    nes_multi_reader #(.NUM_PADS(NP), .HALF_PERIOD(H), .POLL_PERIOD(P2)) dut_short (
        .clk(clk), .reset(reset), .enable(enable), .nes_data(nes_data),
        .nes_latch(nes_latch_b), .nes_clk(nes_clk_b), .buttons(buttons_b),
        .pressed(pressed_b), .valid(valid_b), .overrun(overrun_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int              cyc = 0;
    int              frame_t = 0;
    bit              frame_on = 0;
    logic [8*NP-1:0] pad_btn = '0;
    logic [8*NP-1:0] frame_btn = '0;
    logic            m_latch = 0, m_clk = 0, m_valid = 0, m_overrun = 0;
    logic [8*NP-1:0] m_buttons = '0, m_pressed = '0;
    int              pad_idx [NP];
    logic            prev_pad_clk = 0;

    // One clock of stimulus: advance the reference model, then let the pads react.
    task automatic step();
        bit was_reset;
        int d;
        int e;
        was_reset = reset;
        if (!was_reset && (cyc % P) == P - 1) begin
            if (frame_on && cyc >= frame_t + 1 && cyc <= frame_t + FRAME) begin
                m_overrun = 1;
            end else if (enable) begin
                frame_t   = cyc;
                frame_on  = 1;
                frame_btn = pad_btn;
            end
        end
        @(posedge clk);
        #1;
        if (was_reset) begin
            cyc       = 0;
            frame_on  = 0;
            m_latch   = 0;
            m_clk     = 0;
            m_valid   = 0;
            m_overrun = 0;
            m_buttons = '0;
            m_pressed = '0;
        end else begin
            cyc++;
            m_latch   = 0;
            m_clk     = 0;
            m_valid   = 0;
            m_pressed = '0;
            if (frame_on) begin
                d = cyc - frame_t;
                e = d - 2 * H - 1;
                m_latch = (d >= 1 && d <= 2 * H);
                m_clk   = (e >= 0 && e < 14 * H && ((e / H) % 2) == 1);
                if (d == FRAME) begin
                    m_valid   = 1;
                    m_pressed = frame_btn & ~m_buttons;
                    m_buttons = frame_btn;
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (nes_latch) pad_idx[p] = 0;
            else if (nes_clk && !prev_pad_clk) pad_idx[p]++;
            nes_data[p] = (pad_idx[p] < 8) ? ~pad_btn[8*p + pad_idx[p]] : 1'b1;
        end
        prev_pad_clk = nes_clk;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit found);
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (valid) found = 1;
        end
    endtask

    task automatic test_reset();
        enable  = 1'b1;
        pad_btn = 16'hFFFF;
        reset   = 1'b1;
        repeat (4) step();
        checks += 4;
        if (nes_latch !== 1'b0 || nes_clk !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_pins got latch=%b clk=%b exp 0 0", nes_latch, nes_clk);
        end
        if (buttons !== 16'h0 || pressed !== 16'h0) begin
            errors++; $display("[TB] FAIL reset_buttons got %h/%h exp 0000/0000", buttons, pressed);
        end
        if (valid !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_flags got valid=%b overrun=%b exp 0 0", valid, overrun);
        end
        if (overrun_b !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_overrun_short got %b exp 0", overrun_b);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({nes_latch, nes_clk, valid, overrun, buttons, pressed} !== '0) begin
            errors++; $display("[TB] FAIL reset_release got latch=%b clk=%b valid=%b ovr=%b btn=%h prs=%h exp all 0",
                               nes_latch, nes_clk, valid, overrun, buttons, pressed);
        end
    endtask

    task automatic test_first_frame();
        int   latch_cnt = 0;
        int   pulses = 0;
        int   valids = 0;
        logic last_clk = 0;
        logic [15:0] got_btn = '0, got_prs = '0;
        pad_btn = 16'h0001;
        enable  = 1'b1;
        do_reset();
        for (int i = 0; i < P + FRAME + 8; i++) begin
            step();
            checks += 4;
            if (nes_latch !== m_latch) begin
                errors++; $display("[TB] FAIL frame_latch c=%0d got %b exp %b", cyc, nes_latch, m_latch);
            end
            if (nes_clk !== m_clk) begin
                errors++; $display("[TB] FAIL frame_clk c=%0d got %b exp %b", cyc, nes_clk, m_clk);
            end
            if (valid !== m_valid) begin
                errors++; $display("[TB] FAIL frame_valid c=%0d got %b exp %b", cyc, valid, m_valid);
            end
            if (nes_latch && nes_clk) begin
                errors++; $display("[TB] FAIL frame_overlap c=%0d got latch=1 clk=1 exp not both", cyc);
            end
            if (nes_latch) latch_cnt++;
            if (nes_clk && !last_clk) pulses++;
            last_clk = nes_clk;
            if (valid) begin
                valids++;
                got_btn = buttons;
                got_prs = pressed;
            end
        end
        checks += 5;
        if (latch_cnt !== 2 * H) begin
            errors++; $display("[TB] FAIL first_latch_len got %0d exp %0d", latch_cnt, 2 * H);
        end
        if (pulses !== 7) begin
            errors++; $display("[TB] FAIL first_clk_pulses got %0d exp 7", pulses);
        end
        if (valids !== 1) begin
            errors++; $display("[TB] FAIL first_valid_count got %0d exp 1", valids);
        end
        if (got_btn !== 16'h0001) begin
            errors++; $display("[TB] FAIL first_buttons got %h exp 0001", got_btn);
        end
        if (got_prs !== 16'h0001) begin
            errors++; $display("[TB] FAIL first_pressed got %h exp 0001", got_prs);
        end
    endtask

    task automatic test_repeat_frame();
        bit found;
        wait_valid(2 * P, found);
        checks += 3;
        if (!found || !m_valid) begin
            errors++; $display("[TB] FAIL repeat_valid got found=%b exp model_valid=1 found=1 (model=%b)", found, m_valid);
        end
        if (buttons !== 16'h0001) begin
            errors++; $display("[TB] FAIL repeat_buttons got %h exp 0001", buttons);
        end
        if (pressed !== 16'h0000) begin
            errors++; $display("[TB] FAIL repeat_pressed got %h exp 0000", pressed);
        end
    endtask

    task automatic test_bit_order();
        bit found;
        logic [7:0] one;
        pad_btn = 16'h8801;
        wait_valid(2 * P, found);
        checks += 3;
        if (!found) begin
            errors++; $display("[TB] FAIL order_timeout got no valid exp valid");
        end
        if (buttons[15:8] !== 8'h88) begin
            errors++; $display("[TB] FAIL order_pad1 got %h exp 88", buttons[15:8]);
        end
        if (pressed !== m_pressed) begin
            errors++; $display("[TB] FAIL order_pressed got %h exp %h", pressed, m_pressed);
        end
        for (int b = 0; b < 8; b++) begin
            one     = 8'h01 << b;
            pad_btn = {one, 8'h80 >> b};
            wait_valid(2 * P, found);
            checks++;
            if (!found || buttons !== m_buttons || pressed !== m_pressed) begin
                errors++; $display("[TB] FAIL walk_bit%0d got found=%b btn=%h prs=%h exp btn=%h prs=%h",
                                   b, found, buttons, pressed, m_buttons, m_pressed);
            end
        end
    endtask

    task automatic test_enable_gate();
        int  latch_cnt = 0;
        int  valids = 0;
        bit  found;
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (nes_latch) latch_cnt++;
            if (valid) valids++;
        end
        checks += 3;
        if (latch_cnt !== 0) begin
            errors++; $display("[TB] FAIL gate_latch got %0d cycles exp 0", latch_cnt);
        end
        if (valids !== 0) begin
            errors++; $display("[TB] FAIL gate_valid got %0d pulses exp 0", valids);
        end
        if (overrun !== 1'b0) begin
            errors++; $display("[TB] FAIL gate_overrun got %b exp 0", overrun);
        end
        enable  = 1'b1;
        pad_btn = 16'h4212;
        wait_valid(2 * P + 10, found);
        checks++;
        if (!found || buttons !== m_buttons || buttons !== 16'h4212) begin
            errors++; $display("[TB] FAIL gate_resume got found=%b btn=%h exp btn=4212", found, buttons);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        bit hit = 0;
        do_reset();
        pad_btn = 16'($urandom) | 16'h0100;
        for (int i = 0; i < 2 * P && !hit; i++) begin
            step();
            if (frame_on && cyc - frame_t == 9 * H + 1) hit = 1;
        end
        checks += 2;
        if (!hit || nes_clk !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset_reach got hit=%b clk=%b exp 1 1", hit, nes_clk);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        if ({nes_latch, nes_clk, valid, overrun, buttons, pressed} !== '0) begin
            errors++; $display("[TB] FAIL midreset_outputs got latch=%b clk=%b valid=%b ovr=%b btn=%h prs=%h exp all 0",
                               nes_latch, nes_clk, valid, overrun, buttons, pressed);
        end
        wait_valid(2 * P, found);
        checks += 2;
        if (!found || buttons !== pad_btn) begin
            errors++; $display("[TB] FAIL midreset_frame_buttons got found=%b btn=%h exp %h", found, buttons, pad_btn);
        end
        if (pressed !== pad_btn) begin
            errors++; $display("[TB] FAIL midreset_frame_pressed got %h exp %h", pressed, pad_btn);
        end
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 10 * P; i++) begin
            if ((cyc % P) == 40) begin
                pad_btn = 16'($urandom);
                enable  = ($urandom_range(0, 3) != 0);
            end
            step();
            checks += 3;
            if (nes_latch !== m_latch || nes_clk !== m_clk) begin
                errors++; $display("[TB] FAIL rand_pins c=%0d got %b%b exp %b%b", cyc, nes_latch, nes_clk, m_latch, m_clk);
            end
            if (valid !== m_valid || pressed !== m_pressed) begin
                errors++; $display("[TB] FAIL rand_pulse c=%0d got v=%b p=%h exp v=%b p=%h", cyc, valid, pressed, m_valid, m_pressed);
            end
            if (buttons !== m_buttons || overrun !== m_overrun) begin
                errors++; $display("[TB] FAIL rand_state c=%0d got b=%h o=%b exp b=%h o=%b", cyc, buttons, overrun, m_buttons, m_overrun);
            end
        end
    endtask

    task automatic test_overrun();
        int   first_ov;
        logic exp_ov;
        enable = 1'b1;
        do_reset();
        // First accepted tick at P2-1; the next tick lands inside that frame when 2*P2-1 <= P2-1+FRAME.
        first_ov = (2 * P2 - 1 <= P2 - 1 + FRAME) ? 2 * P2 : 32'h7fffffff;
        for (int i = 0; i < 120; i++) begin
            step();
            exp_ov = (cyc >= first_ov);
            checks++;
            if (overrun_b !== exp_ov) begin
                errors++; $display("[TB] FAIL short_overrun c=%0d got %b exp %b", cyc, overrun_b, exp_ov);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (overrun_b !== 1'b0) begin
            errors++; $display("[TB] FAIL short_overrun_clear got %b exp 0", overrun_b);
        end
    endtask

    initial begin
        for (int p = 0; p < NP; p++) pad_idx[p] = 8;
        $display("[TB] nes_multi_reader bench starting");
        test_reset();
        test_first_frame();
        test_repeat_frame();
        test_bit_order();
        test_enable_gate();
        test_reset_mid_frame();
        test_random_frames();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
